// File: rtl/am_request_scheduler.sv
// Round-robin scheduler sharing one folded associative memory among NUM_REQ
// hypervector producers. One query in flight at a time; the query HV is held in
// a register so the AM sees a stable input across all of its folds.
// Optional build macro AM_SCHED_STATS_EN adds per-requester completion counters
// (stat_count_o) and a busy flag (stat_busy_o).

`ifndef HV_DIMENSION
`define HV_DIMENSION 2000
`endif

module am_request_scheduler #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned REQ_ID_WIDTH = 2,
  parameter int unsigned HV_DIM       = `HV_DIMENSION
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
`ifdef AM_SCHED_STATS_EN
  output logic [NUM_REQ*16-1:0]     stat_count_o,
  output logic                      stat_busy_o,
`endif
  input  logic [NUM_REQ-1:0]        req_hvin_valid_i,
  output logic [NUM_REQ-1:0]        req_hvin_ready_o,
  input  logic [NUM_REQ*HV_DIM-1:0] req_hvin_i,
  output logic [NUM_REQ-1:0]        req_dout_valid_o,
  input  logic [NUM_REQ-1:0]        req_dout_ready_i,
  output logic                      req_valence_o,
  output logic                      req_arousal_o,
  output logic                      am_hvin_valid_o,
  input  logic                      am_hvin_ready_i,
  output logic [HV_DIM-1:0]         am_hvin_o,
  input  logic                      am_dout_valid_i,
  output logic                      am_dout_ready_o,
  input  logic                      am_valence_i,
  input  logic                      am_arousal_i
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StReturn} state_e;

  state_e                  state_q, state_d;
  logic [REQ_ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [REQ_ID_WIDTH-1:0] owner_q, owner_d;
  logic [HV_DIM-1:0]       hv_q, hv_d;
  logic                    res_valence_q, res_valence_d;
  logic                    res_arousal_q, res_arousal_d;

  logic                    grant_valid;
  logic [REQ_ID_WIDTH-1:0] grant;
  logic                    idle_fire;
  logic                    ret_fire;

  // Round-robin search starting at rr_ptr_q, wrapping modulo NUM_REQ.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_ptr_q) + k) % NUM_REQ;
      if (!grant_valid && req_hvin_valid_i[idx]) begin
        grant_valid = 1'b1;
        grant       = REQ_ID_WIDTH'(idx);
      end
    end
  end

  assign idle_fire = (state_q == StIdle) && grant_valid;
  assign ret_fire  = (state_q == StReturn) && req_dout_ready_i[owner_q];

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (grant_valid)     state_d = StIssue;
      StIssue:  if (am_hvin_ready_i) state_d = StWait;
      StWait:   if (am_dout_valid_i) state_d = StReturn;
      StReturn: if (ret_fire)        state_d = StIdle;
      default:                       state_d = StIdle;
    endcase
  end

  // Datapath next values: the query HV only changes on the requester fire.
  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    hv_d          = hv_q;
    res_valence_d = res_valence_q;
    res_arousal_d = res_arousal_q;
    if (idle_fire) begin
      hv_d     = req_hvin_i[32'(grant)*HV_DIM +: HV_DIM];
      owner_d  = grant;
      rr_ptr_d = (grant == REQ_ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
    end
    if ((state_q == StWait) && am_dout_valid_i) begin
      res_valence_d = am_valence_i;
      res_arousal_d = am_arousal_i;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      hv_q          <= '0;
      res_valence_q <= 1'b0;
      res_arousal_q <= 1'b0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      hv_q          <= hv_d;
      res_valence_q <= res_valence_d;
      res_arousal_q <= res_arousal_d;
    end
  end

  // Outputs; ready is gated by reset so nothing is offered while held in reset.
  always_comb begin
    req_hvin_ready_o = '0;
    req_dout_valid_o = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_hvin_ready_o[i] = rst_ni && idle_fire && (grant == REQ_ID_WIDTH'(i));
      req_dout_valid_o[i] = (state_q == StReturn) && (owner_q == REQ_ID_WIDTH'(i));
    end
    am_hvin_valid_o = (state_q == StIssue);
    am_dout_ready_o = (state_q == StWait);
    am_hvin_o       = hv_q;
    req_valence_o   = res_valence_q;
    req_arousal_o   = res_arousal_q;
  end

`ifdef AM_SCHED_STATS_EN
  logic [NUM_REQ-1:0][15:0] stat_q;

  // Saturating completion counters, one per requester.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_q <= '0;
    end else if (ret_fire && (stat_q[owner_q] != 16'hFFFF)) begin
      stat_q[owner_q] <= stat_q[owner_q] + 16'd1;
    end
  end

  assign stat_count_o = stat_q;
  assign stat_busy_o  = (state_q != StIdle);
`endif

endmodule

// File: tb/tb_am_request_scheduler.sv
// Self-checking bench for am_request_scheduler: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.

module tb_am_request_scheduler;

  localparam int N = 4;
  localparam int W = 2;
  localparam int D = 64;

  logic           clk = 1'b0;
  logic           rst_ni;
  logic [N-1:0]   req_hvin_valid, req_hvin_ready, req_dout_valid, req_dout_ready;
  logic [N*D-1:0] req_hvin;
  logic           req_valence, req_arousal;
  logic           am_hvin_valid, am_hvin_ready, am_dout_valid, am_dout_ready;
  logic           am_valence, am_arousal;
  logic [D-1:0]   am_hvin;
`ifdef AM_SCHED_STATS_EN
  logic [N*16-1:0] stat_count;
  logic            stat_busy;
`endif

  am_request_scheduler #(.NUM_REQ(N), .REQ_ID_WIDTH(W), .HV_DIM(D)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
`ifdef AM_SCHED_STATS_EN
    .stat_count_o     (stat_count),
    .stat_busy_o      (stat_busy),
`endif
    .req_hvin_valid_i (req_hvin_valid),
    .req_hvin_ready_o (req_hvin_ready),
    .req_hvin_i       (req_hvin),
    .req_dout_valid_o (req_dout_valid),
    .req_dout_ready_i (req_dout_ready),
    .req_valence_o    (req_valence),
    .req_arousal_o    (req_arousal),
    .am_hvin_valid_o  (am_hvin_valid),
    .am_hvin_ready_i  (am_hvin_ready),
    .am_hvin_o        (am_hvin),
    .am_dout_valid_i  (am_dout_valid),
    .am_dout_ready_o  (am_dout_ready),
    .am_valence_i     (am_valence),
    .am_arousal_i     (am_arousal)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Transaction-level reference: phase 0 waiting for a grant, 1 offering to
  // the AM, 2 awaiting the AM result, 3 returning the result to the owner.
  int           m_phase, m_ptr, m_owner;
  logic [D-1:0] m_hv;
  logic         m_v, m_a;
  int           m_cnt[N];
  int           grants[$];

  // Random environment state.
  bit           auto_mode = 1'b0;
  bit           pend[N];
  logic [D-1:0] pend_hv[N];
  bit           am_busy;
  int           am_cnt;
  logic         am_res_v, am_res_a;

  task automatic check(input string nm, input logic [D-1:0] act, input logic [D-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic int rr_grant(input int ptr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] r;
    r = '0;
    if (i >= 0) r[i] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_owner = 0; m_hv = '0; m_v = 1'b0; m_a = 1'b0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  task automatic model_compare();
    int g;
    g = rr_grant(m_ptr, req_hvin_valid);
    check("m_hvin_ready", req_hvin_ready, (m_phase == 0) ? onehot(g) : '0);
    check("m_am_hvin_valid", am_hvin_valid, m_phase == 1);
    check("m_am_dout_ready", am_dout_ready, m_phase == 2);
    check("m_dout_valid", req_dout_valid, (m_phase == 3) ? onehot(m_owner) : '0);
    check("m_am_hvin", am_hvin, m_hv);
    check("m_valence", req_valence, m_v);
    check("m_arousal", req_arousal, m_a);
`ifdef AM_SCHED_STATS_EN
    for (int i = 0; i < N; i++) check("m_stat_count", stat_count[i*16 +: 16], m_cnt[i]);
    check("m_stat_busy", stat_busy, m_phase != 0);
`endif
  endtask

  task automatic model_update();
    int g;
    g = rr_grant(m_ptr, req_hvin_valid);
    case (m_phase)
      0: if (g >= 0) begin
        m_hv = req_hvin[g*D +: D]; m_owner = g; m_ptr = (g + 1) % N; m_phase = 1;
        grants.push_back(g);
      end
      1: if (am_hvin_ready) m_phase = 2;
      2: if (am_dout_valid) begin m_v = am_valence; m_a = am_arousal; m_phase = 3; end
      3: if (req_dout_ready[m_owner]) begin
        m_phase = 0;
        if (m_cnt[m_owner] < 16'hFFFF) m_cnt[m_owner]++;
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic env_bookkeep();
    for (int i = 0; i < N; i++) if (req_hvin_valid[i] && req_hvin_ready[i]) pend[i] = 1'b0;
    if (am_busy) begin
      if (am_dout_valid && am_dout_ready) am_busy = 1'b0;
      else if (am_cnt > 0) am_cnt--;
    end else if (am_hvin_valid && am_hvin_ready) begin
      am_busy = 1'b1; am_cnt = $urandom_range(0, 6);
      am_res_v = ^am_hvin; am_res_a = am_hvin[0];
    end
  endtask

  task automatic env_drive();
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && $urandom_range(0, 2) == 0) begin
        pend[i] = 1'b1; pend_hv[i] = {$urandom, $urandom};
      end
      req_hvin_valid[i] = pend[i];
      req_hvin[i*D +: D] = pend_hv[i];
      req_dout_ready[i] = 1'($urandom_range(0, 1));
    end
    am_hvin_ready = !am_busy && ($urandom_range(0, 2) != 0);
    am_dout_valid = am_busy && (am_cnt == 0);
    am_valence = am_dout_valid ? am_res_v : 1'($urandom);
    am_arousal = am_dout_valid ? am_res_a : 1'($urandom);
  endtask

  // One clock: compare at the falling edge, advance the model, cross the edge.
  task automatic step();
    @(negedge clk);
    model_compare();
    model_update();
    if (auto_mode) env_bookkeep();
    @(posedge clk);
    #1;
    if (auto_mode) env_drive();
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    req_hvin_valid = '0; req_hvin = '0; req_dout_ready = '0;
    am_hvin_ready = 1'b0; am_dout_valid = 1'b0; am_valence = 1'b0; am_arousal = 1'b0;
    am_busy = 1'b0; am_cnt = 0;
    for (int i = 0; i < N; i++) begin pend[i] = 1'b0; pend_hv[i] = '0; end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Drives one full query with chosen stalls; checks grant, hold and return.
  task automatic run_query(input int exp_g, input int d_issue, input int d_wait,
                           input int d_ret, input logic v, input logic a);
    logic [N-1:0] oh;
    logic [D-1:0] snap;
    oh = onehot(exp_g);
    #1;
    check("q_grant", req_hvin_ready, oh);
    step();
    snap = am_hvin;
    check("q_issue_valid", am_hvin_valid, 1'b1);
    for (int i = 0; i < d_issue; i++) begin
      am_hvin_ready = 1'b0;
      step();
      check("q_hv_stable_issue", am_hvin, snap);
      check("q_no_ready_issue", req_hvin_ready, '0);
    end
    am_hvin_ready = 1'b1;
    step();
    am_hvin_ready = 1'b0;
    for (int i = 0; i < d_wait; i++) begin
      step();
      check("q_hv_stable_wait", am_hvin, snap);
      check("q_no_ready_wait", req_hvin_ready, '0);
    end
    am_dout_valid = 1'b1; am_valence = v; am_arousal = a;
    step();
    am_dout_valid = 1'b0; am_valence = ~v; am_arousal = ~a;
    for (int i = 0; i < d_ret; i++) begin
      req_dout_ready = N'($urandom) & ~oh;
      step();
      check("q_ret_hold_valid", req_dout_valid, oh);
      check("q_ret_hold_val", {req_valence, req_arousal}, {v, a});
      check("q_ret_no_ready", req_hvin_ready, '0);
    end
    req_dout_ready = oh;
    #1;
    check("q_ret_valid", req_dout_valid, oh);
    check("q_ret_result", {req_valence, req_arousal}, {v, a});
    step();
    req_dout_ready = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n0;
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};

    rst_ni = 1'b0;
    do_reset();
    check("rst_ready", req_hvin_ready, '0);
    check("rst_dout_valid", req_dout_valid, '0);
    check("rst_am_valid", {am_hvin_valid, am_dout_ready}, 2'b00);
    check("rst_am_hvin", am_hvin, '0);

    // Single request on requester 2 with an all-ones HV.
    req_hvin_valid = 4'b0100;
    req_hvin[2*D +: D] = '1;
    run_query(2, 0, 0, 0, 1'b1, 1'b0);
    check("t1_am_hvin_ones", am_hvin, '1);
    req_hvin_valid = 4'b1111;
    #1;
    check("t1_ptr_is_3", req_hvin_ready, 4'b1000);

    // All requesters valid continuously: strict rotation.
    do_reset();
    for (int i = 0; i < N; i++) req_hvin[i*D +: D] = {16'(i), 48'hA5A5_0000_1234 + 48'(i)};
    req_hvin_valid = 4'b1111;
    for (int i = 0; i < 5; i++) run_query(exp_order[i], 0, 0, 0, 1'(i), 1'(i >> 1));

    // AM stalls: 5 cycles before accept, 40 cycles before result; requester 1
    // then stalls the return for 10 cycles while others pulse dout_ready.
    run_query(1, 5, 40, 10, 1'b0, 1'b1);
    run_query(2, 0, 0, 0, 1'b1, 1'b1);

    // Asynchronous reset in the middle of WAIT.
    #1;
    step();
    am_hvin_ready = 1'b1;
    step();
    am_hvin_ready = 1'b0;
    step();
    check("t5_in_wait", am_dout_ready, 1'b1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("t5_async_ready", req_hvin_ready, '0);
    check("t5_async_am", {am_hvin_valid, am_dout_ready, req_valence, req_arousal}, 4'b0000);
    check("t5_async_dout", req_dout_valid, '0);
    check("t5_async_hvin", am_hvin, '0);
    do_reset();
    req_hvin_valid = 4'b1111;
    run_query(0, 0, 2, 0, 1'b1, 1'b0);

    // Randomized traffic.
    do_reset();
    n0 = grants.size();
    auto_mode = 1'b1;
    env_drive();
    repeat (3000) step();
    auto_mode = 1'b0;
    check("rand_progress", grants.size() - n0 > 50, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/am_request_scheduler.md
Name: am_request_scheduler

Overview:
- Round-robin scheduler that shares one folded associative_memory instance among NUM_REQ hypervector producers, for example several encoder windows or sensor-fusion channels.
- Accepts one query at a time and registers the query HV.
- Holds that HV stable for the whole multi-fold AM computation.
- Returns valence/arousal to the requester that issued the query.
- Sits between the encoder outputs and the associative_memory hvin/dout handshakes.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- REQ_ID_WIDTH, 2, width of the owner/round-robin index; equals clog2(NUM_REQ).
- HV_DIM, `HV_DIMENSION, query hypervector width (2000).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- req_hvin_valid  in  NUM_REQ  per-requester query valid
- req_hvin_ready  out  NUM_REQ  per-requester query accept (at most one bit high)
- req_hvin  in  NUM_REQ*HV_DIM  flattened queries; requester i occupies bits [i*HV_DIM +: HV_DIM]
- req_dout_valid  out  NUM_REQ  per-requester result valid (at most one bit high)
- req_dout_ready  in  NUM_REQ  per-requester result accept
- req_valence  out  1  result valence, shared by all requesters
- req_arousal  out  1  result arousal, shared by all requesters
- am_hvin_valid  out  1  query valid to the AM
- am_hvin_ready  in  1  query ready from the AM
- am_hvin  out  HV_DIM  registered query to the AM
- am_dout_valid  in  1  result valid from the AM
- am_dout_ready  out  1  result ready to the AM
- am_valence  in  1  valence from the AM
- am_arousal  in  1  arousal from the AM

Behaviour:
- States: IDLE, ISSUE, WAIT, RETURN. Encoding is free.
- Reset (rst=0, async) clears every register and every output to 0:
  - state=IDLE, rr_ptr=0, owner=0, hv_reg=0.
  - res_valence=0, res_arousal=0.
  - All valid/ready outputs low.
  - The AM must be reset on the same reset; reset mid-operation abandons the in-flight query with no result.
- IDLE:
  - grant = first i with req_hvin_valid[i], searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_hvin_ready[grant]=1 combinationally; all other ready bits are 0. No valid input means no ready.
  - On fire: hv_reg<=req_hvin[grant], owner<=grant, rr_ptr<=(grant+1) mod NUM_REQ (wraps NUM_REQ-1 to 0), state<=ISSUE.
- ISSUE:
  - am_hvin_valid=1, am_hvin=hv_reg.
  - On am_hvin_ready: state<=WAIT.
  - am_hvin_valid rises one cycle after the requester fire.
- WAIT:
  - am_dout_ready=1.
  - On am_dout_valid: res_valence<=am_valence, res_arousal<=am_arousal, state<=RETURN.
- RETURN:
  - req_dout_valid[owner]=1; req_valence/req_arousal driven from res_*.
  - On req_dout_ready[owner]: state<=IDLE.
  - Ready bits of non-owners are ignored.
- hv_reg must not change outside the IDLE fire. The AM indexes hvin fold-by-fold across all prototypes, so am_hvin must stay constant from ISSUE entry until the WAIT exit.
- am_hvin is driven from hv_reg in every state.
- req_hvin_ready is 0 in ISSUE, WAIT and RETURN: exactly one query is in flight.
- Requester valid/data must be held until accepted. Deasserting valid before grant just removes that requester from arbitration.
- Simultaneous requests: the grant goes to the nearest index at or after rr_ptr. The granted requester becomes lowest priority for the next round.
- Minimum overhead per query:
  - 1 cycle (IDLE fire to ISSUE).
  - 1 cycle (WAIT to RETURN).
  - 1 cycle (RETURN handshake).
  - Plus the AM's own latency.
- Back-to-back: the next grant can fire in the first IDLE cycle after the RETURN fire.

Optional Feature:
- Macro: AM_SCHED_STATS_EN.
- Defined:
  - Adds output port stat_count (NUM_REQ*16): one 16-bit counter per requester.
  - A counter increments on every RETURN fire for that owner and saturates at 16'hFFFF.
  - Counters reset to 0 on rst.
  - Adds output stat_busy (1), high in ISSUE, WAIT and RETURN.
- Undefined: neither port nor any counter logic exists; behaviour is otherwise identical.

Test Plan:
- Single request on requester 2 with HV=all-ones, AM returns valence=1, arousal=0:
  - req_hvin_ready[2] is high in the same cycle.
  - am_hvin_valid rises 1 cycle later with am_hvin=all-ones.
  - req_dout_valid[2]=1 with valence=1, arousal=0.
  - rr_ptr=3 afterwards.
- All 4 requesters valid continuously from reset: grant order is 0,1,2,3,0. No requester receives two grants while another is waiting.
- AM holds am_hvin_ready low 5 cycles, then am_dout_valid arrives 40 cycles later: am_hvin is bit-identical in every cycle from ISSUE to the WAIT exit, and no second requester gets ready.
- Requester 1 holds req_dout_ready low 10 cycles in RETURN:
  - req_dout_valid[1] and the result stay stable.
  - req_dout_ready pulses on requesters 0 and 3 have no effect.
  - Requester 0's pending query is not accepted until the RETURN fire.
- Assert rst=0 asynchronously mid-WAIT: all outputs go to 0 immediately with no clock edge. After release, the first grant goes to requester 0.
- With AM_SCHED_STATS_EN defined:
  - 3 completions on requester 1 give stat_count[1]=3 and the others 0.
  - A counter forced to 16'hFFFF stays at 16'hFFFF after another completion.
